blake2_block_sched: RTL

- Sequencer between the byte-stream front end and the BLAKE2b compression core.
- Writes incoming message bytes into the core's 64-byte message memory and tracks the byte counter t.
- Zero-pads the final block, issues one compression start per block with first/last flags, then streams nn digest bytes out.
- One instance per hash engine; the core's message memory and digest read port are owned by this block.

---
 rtl/blake2_block_sched.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/blake2_block_sched.sv
// BLAKE2b block sequencer: fills the core's message memory, zero-pads the final block,
// starts one compression per block and streams the digest. Define BLAKE2_SCHED_ERR_EN for err_o.
module blake2_block_sched #(
  parameter int unsigned BLOCK_BYTES = 64,
  parameter int unsigned T_W         = 64,
  parameter int unsigned NN_MAX      = 64,
  localparam int unsigned AW         = $clog2(BLOCK_BYTES),
  localparam int unsigned IW         = $clog2(NN_MAX)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     kk_i,
  input  logic [7:0]     nn_i,
  input  logic [T_W-1:0] ll_i,
  input  logic           data_v_i,
  input  logic [7:0]     data_i,
  input  logic [AW-1:0]  data_idx_i,
  input  logic           block_first_i,
  output logic           ready_o,
  output logic           msg_we_o,
  output logic [AW-1:0]  msg_addr_o,
  output logic [7:0]     msg_wdata_o,
  output logic           core_start_o,
  output logic           core_first_o,
  output logic           core_last_o,
  output logic [T_W-1:0] core_t_o,
  input  logic           core_done_i,
  output logic [IW-1:0]  hash_idx_o,
  input  logic [7:0]     hash_i,
  output logic           hash_v_o,
  output logic [7:0]     hash_o,
  output logic           hash_finished_o
`ifdef BLAKE2_SCHED_ERR_EN
  ,
  output logic           err_o
`endif
);

  localparam int unsigned NW = $clog2(NN_MAX + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PAD,
    S_COMP,
    S_OUT
  } state_t;

  state_t         r_state;
  logic [T_W-1:0] r_t;
  logic           r_first_flag;
  logic           r_last;
  logic [AW-1:0]  r_pad_addr;
  logic [IW-1:0]  r_hash_idx;
  logic           r_ready;
  logic           r_msg_we;
  logic [AW-1:0]  r_msg_addr;
  logic [7:0]     r_msg_wdata;
  logic           r_core_start;
  logic           r_core_first;
  logic           r_core_last;
  logic           r_hash_v;
  logic [7:0]     r_hash;
  logic           r_hash_fin;

  logic [T_W-1:0] w_total;
  logic [T_W-1:0] w_t_base;
  logic [T_W-1:0] w_t_next;
  logic           w_final;
  logic           w_take;
  logic [NW-1:0]  w_nn_eff;
  logic           w_hash_last;

  // A block_first byte restarts the count; the key block adds a full block to the total.
  assign w_total     = ll_i + ((kk_i != 8'd0) ? T_W'(BLOCK_BYTES) : '0);
  assign w_t_base    = block_first_i ? '0 : r_t;
  assign w_t_next    = w_t_base + T_W'(1);
  assign w_final     = (w_t_next == w_total);
  assign w_take      = data_v_i & (((r_state == S_IDLE) & block_first_i) | (r_state == S_FILL));
  assign w_nn_eff    = ((nn_i == 8'd0) || (32'(nn_i) > NN_MAX)) ? NW'(NN_MAX) : NW'(nn_i);
  assign w_hash_last = (NW'(r_hash_idx) == (w_nn_eff - NW'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_t          <= '0;
      r_first_flag <= 1'b0;
      r_last       <= 1'b0;
      r_pad_addr   <= '0;
      r_hash_idx   <= '0;
      r_ready      <= 1'b1;
      r_msg_we     <= 1'b0;
      r_msg_addr   <= '0;
      r_msg_wdata  <= '0;
      r_core_start <= 1'b0;
      r_core_first <= 1'b0;
      r_core_last  <= 1'b0;
      r_hash_v     <= 1'b0;
      r_hash       <= '0;
      r_hash_fin   <= 1'b0;
    end else begin
      r_msg_we     <= 1'b0;
      r_msg_addr   <= '0;
      r_msg_wdata  <= '0;
      r_core_start <= 1'b0;
      r_core_first <= 1'b0;
      r_core_last  <= 1'b0;
      r_hash_v     <= 1'b0;
      r_hash       <= '0;
      r_hash_fin   <= 1'b0;
      case (r_state)
        S_IDLE, S_FILL: begin
          if (w_take) begin
            if (block_first_i) begin
              r_first_flag <= 1'b1;
            end
            if (block_first_i && (w_total == '0)) begin
              // Empty message: the trigger byte is discarded and the whole block is padding.
              r_t        <= '0;
              r_pad_addr <= '0;
              r_ready    <= 1'b0;
              r_state    <= S_PAD;
            end else begin
              r_t         <= w_t_next;
              r_msg_we    <= 1'b1;
              r_msg_addr  <= data_idx_i;
              r_msg_wdata <= data_i;
              if (data_idx_i == LAST_IDX) begin
                r_state      <= S_COMP;
                r_ready      <= 1'b0;
                r_last       <= w_final;
                r_core_start <= 1'b1;
                r_core_first <= block_first_i | r_first_flag;
                r_core_last  <= w_final;
                r_first_flag <= 1'b0;
              end else if (w_final) begin
                r_state    <= S_PAD;
                r_ready    <= 1'b0;
                r_pad_addr <= data_idx_i + AW'(1);
              end else begin
                r_state <= S_FILL;
              end
            end
          end
        end
        S_PAD: begin
          r_msg_we    <= 1'b1;
          r_msg_addr  <= r_pad_addr;
          r_msg_wdata <= 8'h00;
          r_pad_addr  <= r_pad_addr + AW'(1);
          if (r_pad_addr == LAST_IDX) begin
            r_state      <= S_COMP;
            r_last       <= 1'b1;
            r_core_start <= 1'b1;
            r_core_first <= r_first_flag;
            r_core_last  <= 1'b1;
            r_first_flag <= 1'b0;
          end
        end
        S_COMP: begin
          // Start pulse is visible during the first COMP cycle, so a same-cycle done is honoured.
          if (core_done_i) begin
            if (r_last) begin
              r_state    <= S_OUT;
              r_hash_idx <= '0;
            end else begin
              r_state <= S_FILL;
              r_ready <= 1'b1;
            end
          end
        end
        S_OUT: begin
          r_hash_v   <= 1'b1;
          r_hash     <= hash_i;
          r_hash_idx <= r_hash_idx + IW'(1);
          if (w_hash_last) begin
            r_hash_fin <= 1'b1;
            r_hash_idx <= '0;
            r_ready    <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef BLAKE2_SCHED_ERR_EN
  logic w_idx_bad;
  logic r_err;

  // Expected byte position is the running count modulo the block size.
  assign w_idx_bad = (data_idx_i != w_t_base[AW-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_take && (r_state == S_IDLE)) begin
      r_err <= w_idx_bad;
    end else if ((data_v_i && !r_ready) || (w_take && (block_first_i || w_idx_bad))) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

  assign ready_o         = r_ready;
  assign msg_we_o        = r_msg_we;
  assign msg_addr_o      = r_msg_addr;
  assign msg_wdata_o     = r_msg_wdata;
  assign core_start_o    = r_core_start;
  assign core_first_o    = r_core_first;
  assign core_last_o     = r_core_last;
  assign core_t_o        = r_t;
  assign hash_idx_o      = r_hash_idx;
  assign hash_v_o        = r_hash_v;
  assign hash_o          = r_hash;
  assign hash_finished_o = r_hash_fin;

endmodule
